if_fetch_ctrl: RTL and testbench
================================

# if_fetch_ctrl

Fetch-side responder to the pipeline flow controller. It owns the program counter and sequences single-outstanding instruction requests to the Icache. It obeys the flow controller's jump and keep (stall) commands, including discard of in-flight responses after a redirect. It presents fetched instruction/PC pairs to the IF/ID register and raises a stall request back to the flow controller while a fetch is unresolved.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- fc_jump_flag_if_i  in  1  redirect request from flow control (single-cycle pulse)
- fc_jump_pc_if_i  in  32  redirect target, valid with flag
- fc_bk_if_i  in  1  keep: hold current output and PC
- if_req_valid_o  out  1  fetch request to Icache
- if_req_addr_o  out  32  fetch address, word aligned
- icache_req_ready_i  in  1  Icache accepts request
- icache_rsp_valid_i  in  1  instruction returned (one per accepted request)
- icache_rsp_inst_i  in  32  returned instruction
- if_inst_valid_o  out  1  output pair valid to IF/ID
- if_inst_o  out  32  fetched instruction
- if_pc_o  out  32  PC of if_inst_o
- if_stall_req_o  out  1  fetch unresolved, to flow control

## Operation
- State: pc_r (next fetch address), req_pc_r (address of outstanding request), FSM {RESET1, REQ, WAIT, DROP}, output regs.
- RESET1: one cycle after reset release, no request; then REQ.
- REQ: if_req_valid_o=1, addr=pc_r. On valid&&ready: req_pc_r<=pc_r, pc_r<=pc_r+4 (mod 2^32, 0xFFFF_FFFC wraps to 0), go WAIT.
- WAIT: on icache_rsp_valid_i, load if_inst_o/if_pc_o=req_pc_r, set if_inst_valid_o, go REQ. The new request is issued the following cycle, not the same cycle.
- DROP: discard the next response (do not update outputs), go REQ.
- Keep (fc_bk_if_i=1, no jump): no new request is issued (if_req_valid_o=0 in REQ). pc_r and output regs are held. WAIT still captures the response into a one-entry pending buffer. The output is updated from the buffer on the first cycle keep is low.
- Jump (fc_jump_flag_if_i=1), priority over keep and over a response in the same cycle:
  - pc_r<=fc_jump_pc_if_i; if_inst_valid_o<=0; pending buffer cleared.
  - From REQ: go REQ. A request accepted in that same cycle is treated as outstanding, so go DROP instead.
  - From WAIT with no response this cycle: go DROP. With a response this cycle: discard it, go REQ.
  - From DROP: stay DROP.
- if_inst_valid_o clears when IF/ID consumes it: the cycle after it is presented with keep low, unless a new response loads it.
- if_stall_req_o = (state==WAIT || state==DROP || (state==REQ && !icache_req_ready_i)) && !fc_jump_flag_if_i. It is combinational from state and inputs.
- Target low 2 bits are forced to 0.

## Timing
- Reset values: if_req_valid_o=0, if_req_addr_o=RESET_PC, if_inst_valid_o=0, if_inst_o=32'h0000_0013 (NOP), if_pc_o=0, if_stall_req_o=0, pc_r=RESET_PC, FSM=RESET1.
- Reset asserted mid-transaction: all state returns to reset values immediately. A later stray response is ignored because the FSM is not in WAIT.
- Minimum fetch loop: request accepted cycle N, response earliest N+1, output visible N+2, next request N+2. Peak throughput is one instruction per 2 cycles.
- Jump at cycle N: first request to the target at N+1 if no response is outstanding; otherwise the request follows the dropped response.
- At most one outstanding request at any time. icache_rsp_valid_i outside WAIT/DROP is ignored.

## Test plan
- Reset release, Icache always ready, 1-cycle response -> requests at 0x0,0x4,0x8 every 2 cycles; if_pc_o/if_inst_o pair correctly; stall_req high only in WAIT cycles.
- Jump to 0x100 while in WAIT, response with inst 0xDEAD_BEEF arrives 3 cycles later -> response dropped (if_inst_valid_o stays 0); next request addr 0x100.
- Jump to 0x200 in the same cycle as response -> response discarded, next request 0x200, no output update.
- Keep held 4 cycles while response arrives -> outputs unchanged, no request issued; after keep drops, buffered inst appears next cycle, then request pc+4.
- Jump to 0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000 (wrap).
- Assert rst_n low while in WAIT, deliver response after release -> ignored; first request to RESET_PC after RESET1 cycle.

Source files
------------

// File: rtl/if_fetch_ctrl_if.sv
// Signal bundle between the fetch controller, the pipeline flow controller,
// the Icache and the IF/ID register.
//
// Handshakes: a request transfers on a rising clk edge where if_req_valid_o
// and icache_req_ready_i are both high; the Icache answers each accepted
// request with exactly one icache_rsp_valid_i pulse, no earlier than the
// following cycle. if_inst_valid_o/if_inst_o/if_pc_o are taken by IF/ID in
// any cycle where they are presented while fc_bk_if_i is low.
interface if_fetch_ctrl_if;
    // flow controller commands
    logic        fc_jump_flag_if_i;
    logic [31:0] fc_jump_pc_if_i;
    logic        fc_bk_if_i;
    // Icache request/response
    logic        if_req_valid_o;
    logic [31:0] if_req_addr_o;
    logic        icache_req_ready_i;
    logic        icache_rsp_valid_i;
    logic [31:0] icache_rsp_inst_i;
    // IF/ID output pair and stall request
    logic        if_inst_valid_o;
    logic [31:0] if_inst_o;
    logic [31:0] if_pc_o;
    logic        if_stall_req_o;
    // debug view of the fetch FSM state
    logic [1:0]  fetch_state;

    modport master (
        input  fc_jump_flag_if_i, fc_jump_pc_if_i, fc_bk_if_i,
        input  icache_req_ready_i, icache_rsp_valid_i, icache_rsp_inst_i,
        output if_req_valid_o, if_req_addr_o,
        output if_inst_valid_o, if_inst_o, if_pc_o, if_stall_req_o,
        output fetch_state
    );

    modport slave (
        output fc_jump_flag_if_i, fc_jump_pc_if_i, fc_bk_if_i,
        output icache_req_ready_i, icache_rsp_valid_i, icache_rsp_inst_i,
        input  if_req_valid_o, if_req_addr_o,
        input  if_inst_valid_o, if_inst_o, if_pc_o, if_stall_req_o,
        input  fetch_state
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, keeps at most one Icache request
// in flight, follows jump/keep commands from flow control and presents
// instruction/PC pairs to IF/ID.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    if_fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        ST_RESET1 = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DROP   = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

    state_t      state;
    logic [31:0] pc_r;
    logic [31:0] req_pc_r;
    logic        inst_valid_r;
    logic [31:0] inst_r;
    logic [31:0] inst_pc_r;
    // one-entry buffer for a response that arrives while keep is high
    logic        pend_valid_r;
    logic [31:0] pend_inst_r;
    logic [31:0] pend_pc_r;

    logic        jump;
    logic        keep;
    logic [31:0] jump_target;
    logic        req_fire;
    logic        rsp;
    logic        rsp_capture;

    // jump overrides keep, so keep is only honoured without a jump
    assign jump        = bus.fc_jump_flag_if_i;
    assign keep        = bus.fc_bk_if_i && !jump;
    assign jump_target = {bus.fc_jump_pc_if_i[31:2], 2'b00};
    assign rsp         = bus.icache_rsp_valid_i;

    assign bus.if_req_valid_o = (state == ST_REQ) && !keep;
    assign bus.if_req_addr_o  = pc_r;
    assign req_fire           = bus.if_req_valid_o && bus.icache_req_ready_i;
    assign rsp_capture        = (state == ST_WAIT) && rsp && !jump;

    assign bus.if_inst_valid_o = inst_valid_r;
    assign bus.if_inst_o       = inst_r;
    assign bus.if_pc_o         = inst_pc_r;
    assign bus.if_stall_req_o  = ((state == ST_WAIT) || (state == ST_DROP) ||
                                  ((state == ST_REQ) && !bus.icache_req_ready_i)) && !jump;
    assign bus.fetch_state     = state;

    // Fetch sequencing: FSM, PC, output pair and pending buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RESET1;
            pc_r         <= RESET_PC_W;
            req_pc_r     <= '0;
            inst_valid_r <= 1'b0;
            inst_r       <= NOP_INST;
            inst_pc_r    <= '0;
            pend_valid_r <= 1'b0;
            pend_inst_r  <= NOP_INST;
            pend_pc_r    <= '0;
        end else begin
            case (state)
                ST_RESET1: state <= ST_REQ;
                ST_REQ: begin
                    if (req_fire) begin
                        req_pc_r <= pc_r;
                        // a request accepted alongside a jump is stale but still in flight
                        state    <= jump ? ST_DROP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (jump) begin
                        state <= rsp ? ST_REQ : ST_DROP;
                    end else if (rsp) begin
                        state <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    // the stale response retires the outstanding request even
                    // under a fresh jump, otherwise nothing would ever leave DROP
                    if (rsp) begin
                        state <= ST_REQ;
                    end
                end
                default: state <= ST_RESET1;
            endcase

            if (jump) begin
                pc_r <= jump_target;
            end else if (req_fire) begin
                pc_r <= pc_r + 32'd4;
            end

            if (jump) begin
                inst_valid_r <= 1'b0;
                pend_valid_r <= 1'b0;
            end else if (keep) begin
                if (rsp_capture) begin
                    pend_valid_r <= 1'b1;
                    pend_inst_r  <= bus.icache_rsp_inst_i;
                    pend_pc_r    <= req_pc_r;
                end
            end else begin
                if (rsp_capture) begin
                    inst_valid_r <= 1'b1;
                    inst_r       <= bus.icache_rsp_inst_i;
                    inst_pc_r    <= req_pc_r;
                end else if (pend_valid_r) begin
                    inst_valid_r <= 1'b1;
                    inst_r       <= pend_inst_r;
                    inst_pc_r    <= pend_pc_r;
                    pend_valid_r <= 1'b0;
                end else begin
                    inst_valid_r <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios with cycle-exact expectations,
// then a randomized run checked against a transaction-level reference model.
module tb_if_fetch_ctrl;

    logic clk;
    logic rst_n;

    if_fetch_ctrl_if bus ();

    if_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [63:0] exp_q[$];   // {pc, inst} pairs still owed to IF/ID
    logic [31:0] m_next_pc;
    logic [31:0] m_addr;
    bit          m_out;
    bit          m_discard;
    int          m_due;
    int          n_consumed;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // inputs change just after the active edge, outputs are sampled mid-cycle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // one randomized cycle: drive, check against the model, advance the model
    task automatic rand_cycle(input int c, input bit quiet);
        logic [31:0] tgt;
        logic [63:0] front;
        logic        exp_rv;
        logic        exp_st;
        bit          j, k, r, rv;
        if (quiet) begin
            j = 1'b0; k = 1'b0; r = 1'b1;
        end else begin
            j = ($urandom_range(0, 11) == 0);
            k = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) != 0);
        end
        tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        rv  = m_out && (c >= m_due);
        bus.fc_jump_flag_if_i  = j;
        bus.fc_jump_pc_if_i    = tgt;
        bus.fc_bk_if_i         = k;
        bus.icache_req_ready_i = r;
        bus.icache_rsp_valid_i = rv;
        bus.icache_rsp_inst_i  = mem_word(m_addr);
        smp();
        if (c == 0) begin
            exp_rv = 1'b0;
            exp_st = 1'b0;
        end else begin
            exp_rv = !m_out && (!k || j);
            exp_st = !j && (m_out || !r);
        end
        check("rnd_req_valid", bus.if_req_valid_o, exp_rv);
        check("rnd_stall", bus.if_stall_req_o, exp_st);
        if (bus.if_req_valid_o) check("rnd_req_addr", bus.if_req_addr_o, m_next_pc);
        if (bus.if_inst_valid_o && !k) begin
            check("rnd_q_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                front = exp_q.pop_front();
                check("rnd_pc", bus.if_pc_o, front[63:32]);
                check("rnd_inst", bus.if_inst_o, front[31:0]);
                n_consumed++;
            end
        end
        if (rv) begin
            if (!m_discard && !j) exp_q.push_back({m_addr, mem_word(m_addr)});
            m_out = 1'b0;
        end
        if (bus.if_req_valid_o && r) begin
            m_out     = 1'b1;
            m_addr    = m_next_pc;
            m_discard = j;
            m_due     = c + int'($urandom_range(1, 3));
            m_next_pc = m_next_pc + 32'd4;
        end
        if (j) begin
            exp_q.delete();
            m_next_pc = {tgt[31:2], 2'b00};
            if (m_out) m_discard = 1'b1;
        end
        step();
    endtask

    initial begin
        int quiet_start;
        rst_n                  = 1'b0;
        bus.fc_jump_flag_if_i  = 1'b0;
        bus.fc_jump_pc_if_i    = '0;
        bus.fc_bk_if_i         = 1'b0;
        bus.icache_req_ready_i = 1'b1;
        bus.icache_rsp_valid_i = 1'b0;
        bus.icache_rsp_inst_i  = '0;

        // reset values
        repeat (3) step();
        smp();
        check("rst_req_valid", bus.if_req_valid_o, 1'b0);
        check("rst_req_addr", bus.if_req_addr_o, 32'h0);
        check("rst_inst_valid", bus.if_inst_valid_o, 1'b0);
        check("rst_inst", bus.if_inst_o, 32'h0000_0013);
        check("rst_pc", bus.if_pc_o, 32'h0);
        check("rst_stall", bus.if_stall_req_o, 1'b0);

        // basic fetch loop: RESET1 cycle, then 0x0, 0x4, 0x8 every two cycles
        step(); rst_n = 1'b1;
        smp();
        check("r1_req_valid", bus.if_req_valid_o, 1'b0);
        check("r1_stall", bus.if_stall_req_o, 1'b0);
        step(); smp();
        check("f0_req_valid", bus.if_req_valid_o, 1'b1);
        check("f0_req_addr", bus.if_req_addr_o, 32'h0);
        check("f0_stall", bus.if_stall_req_o, 1'b0);
        step(); bus.icache_rsp_valid_i = 1'b1; bus.icache_rsp_inst_i = mem_word(32'h0); smp();
        check("w0_req_valid", bus.if_req_valid_o, 1'b0);
        check("w0_stall", bus.if_stall_req_o, 1'b1);
        step(); bus.icache_rsp_valid_i = 1'b0; smp();
        check("o0_valid", bus.if_inst_valid_o, 1'b1);
        check("o0_pc", bus.if_pc_o, 32'h0);
        check("o0_inst", bus.if_inst_o, mem_word(32'h0));
        check("f1_req_addr", bus.if_req_addr_o, 32'h4);
        check("f1_req_valid", bus.if_req_valid_o, 1'b1);
        check("f1_stall", bus.if_stall_req_o, 1'b0);
        step(); bus.icache_rsp_valid_i = 1'b1; bus.icache_rsp_inst_i = mem_word(32'h4); smp();
        check("w1_valid_cleared", bus.if_inst_valid_o, 1'b0);
        check("w1_stall", bus.if_stall_req_o, 1'b1);
        step(); bus.icache_rsp_valid_i = 1'b0; smp();
        check("o1_valid", bus.if_inst_valid_o, 1'b1);
        check("o1_pc", bus.if_pc_o, 32'h4);
        check("o1_inst", bus.if_inst_o, mem_word(32'h4));
        check("f2_req_addr", bus.if_req_addr_o, 32'h8);

        // jump to 0x100 while waiting; late response must be dropped
        step(); bus.fc_jump_flag_if_i = 1'b1; bus.fc_jump_pc_if_i = 32'h100; smp();
        check("j1_stall", bus.if_stall_req_o, 1'b0);
        check("j1_valid", bus.if_inst_valid_o, 1'b0);
        step(); bus.fc_jump_flag_if_i = 1'b0; smp();
        check("d1_stall", bus.if_stall_req_o, 1'b1);
        check("d1_req_valid", bus.if_req_valid_o, 1'b0);
        step(); smp();
        step(); bus.icache_rsp_valid_i = 1'b1; bus.icache_rsp_inst_i = 32'hDEAD_BEEF; smp();
        check("d3_stall", bus.if_stall_req_o, 1'b1);
        step(); bus.icache_rsp_valid_i = 1'b0; smp();
        check("drop_valid", bus.if_inst_valid_o, 1'b0);
        check("drop_pc_held", bus.if_pc_o, 32'h4);
        check("j1_req_valid", bus.if_req_valid_o, 1'b1);
        check("j1_req_addr", bus.if_req_addr_o, 32'h100);

        // jump to 0x200 in the same cycle as a response
        step(); bus.icache_rsp_valid_i = 1'b1; bus.icache_rsp_inst_i = mem_word(32'h100);
        bus.fc_jump_flag_if_i = 1'b1; bus.fc_jump_pc_if_i = 32'h200; smp();
        check("j2_stall", bus.if_stall_req_o, 1'b0);
        step(); bus.icache_rsp_valid_i = 1'b0; bus.fc_jump_flag_if_i = 1'b0; smp();
        check("j2_valid", bus.if_inst_valid_o, 1'b0);
        check("j2_pc_held", bus.if_pc_o, 32'h4);
        check("j2_inst_held", bus.if_inst_o, mem_word(32'h4));
        check("j2_req_addr", bus.if_req_addr_o, 32'h200);

        // keep held 4 cycles while the response arrives
        step(); bus.fc_bk_if_i = 1'b1; bus.icache_rsp_valid_i = 1'b1;
        bus.icache_rsp_inst_i = mem_word(32'h200); smp();
        check("k1_stall", bus.if_stall_req_o, 1'b1);
        check("k1_valid", bus.if_inst_valid_o, 1'b0);
        step(); bus.icache_rsp_valid_i = 1'b0; smp();
        check("k2_req_valid", bus.if_req_valid_o, 1'b0);
        check("k2_valid", bus.if_inst_valid_o, 1'b0);
        check("k2_pc_held", bus.if_pc_o, 32'h4);
        check("k2_stall", bus.if_stall_req_o, 1'b0);
        step(); smp();
        check("k3_req_valid", bus.if_req_valid_o, 1'b0);
        step(); smp();
        check("k4_req_valid", bus.if_req_valid_o, 1'b0);
        check("k4_valid", bus.if_inst_valid_o, 1'b0);
        step(); bus.fc_bk_if_i = 1'b0; smp();
        check("k5_req_valid", bus.if_req_valid_o, 1'b1);
        check("k5_req_addr", bus.if_req_addr_o, 32'h204);
        check("k5_valid", bus.if_inst_valid_o, 1'b0);
        step(); bus.icache_rsp_valid_i = 1'b1; bus.icache_rsp_inst_i = mem_word(32'h204); smp();
        check("kb_valid", bus.if_inst_valid_o, 1'b1);
        check("kb_pc", bus.if_pc_o, 32'h200);
        check("kb_inst", bus.if_inst_o, mem_word(32'h200));
        check("kb_stall", bus.if_stall_req_o, 1'b1);
        step(); bus.icache_rsp_valid_i = 1'b0; bus.icache_req_ready_i = 1'b0; smp();
        check("k6_pc", bus.if_pc_o, 32'h204);
        check("k6_inst", bus.if_inst_o, mem_word(32'h204));
        check("nr_req_addr", bus.if_req_addr_o, 32'h208);
        check("nr_stall", bus.if_stall_req_o, 1'b1);

        // jump to the top word (low target bits ignored), then wrap to 0
        step(); bus.fc_jump_flag_if_i = 1'b1; bus.fc_jump_pc_if_i = 32'hFFFF_FFFF; smp();
        check("jw_stall", bus.if_stall_req_o, 1'b0);
        check("jw_valid", bus.if_inst_valid_o, 1'b0);
        step(); bus.fc_jump_flag_if_i = 1'b0; bus.icache_req_ready_i = 1'b1; smp();
        check("jw_req_valid", bus.if_req_valid_o, 1'b1);
        check("jw_req_addr", bus.if_req_addr_o, 32'hFFFF_FFFC);
        step(); bus.icache_rsp_valid_i = 1'b1; bus.icache_rsp_inst_i = mem_word(32'hFFFF_FFFC); smp();
        check("jw_wait_stall", bus.if_stall_req_o, 1'b1);
        step(); bus.icache_rsp_valid_i = 1'b0; smp();
        check("jw_pc", bus.if_pc_o, 32'hFFFF_FFFC);
        check("wrap_req_addr", bus.if_req_addr_o, 32'h0);

        // reset asserted while waiting; stray response after release ignored
        step(); smp();
        check("rw_stall", bus.if_stall_req_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("ar_req_valid", bus.if_req_valid_o, 1'b0);
        check("ar_req_addr", bus.if_req_addr_o, 32'h0);
        check("ar_valid", bus.if_inst_valid_o, 1'b0);
        check("ar_inst", bus.if_inst_o, 32'h0000_0013);
        check("ar_pc", bus.if_pc_o, 32'h0);
        check("ar_stall", bus.if_stall_req_o, 1'b0);
        step(); step(); rst_n = 1'b1;
        bus.icache_rsp_valid_i = 1'b1; bus.icache_rsp_inst_i = 32'hBAD0_BAD0; smp();
        check("st_req_valid", bus.if_req_valid_o, 1'b0);
        check("st_stall", bus.if_stall_req_o, 1'b0);
        step(); bus.icache_rsp_valid_i = 1'b0; smp();
        check("st_valid", bus.if_inst_valid_o, 1'b0);
        check("st_req_addr", bus.if_req_addr_o, 32'h0);
        check("st_req_valid2", bus.if_req_valid_o, 1'b1);
        step(); bus.icache_rsp_valid_i = 1'b1; bus.icache_rsp_inst_i = mem_word(32'h0); smp();
        step(); bus.icache_rsp_valid_i = 1'b0; smp();
        check("st_out_pc", bus.if_pc_o, 32'h0);
        check("st_out_inst", bus.if_inst_o, mem_word(32'h0));

        // randomized run against the reference model
        step(); rst_n = 1'b0;
        step(); rst_n = 1'b1;
        exp_q.delete();
        m_next_pc  = 32'h0;
        m_addr     = 32'h0;
        m_out      = 1'b0;
        m_discard  = 1'b0;
        m_due      = 0;
        n_consumed = 0;
        for (int c = 0; c < 2000; c++) rand_cycle(c, 1'b0);
        quiet_start = n_consumed;
        for (int c = 2000; c < 2060; c++) rand_cycle(c, 1'b1);
        check("quiet_progress", (n_consumed - quiet_start) >= 10, 1'b1);
        check("quiet_backlog", exp_q.size() <= 1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
